fa_result_checker: RTL

FA_RESULT_CHECKER -- requirements
Module: fa_result_checker

---
 rtl/fa_result_checker.sv | 114 +++++++++++
 1 files changed

// File: rtl/fa_result_checker.sv
// fa_result_checker: counts full-adder sum/carry matches over a run of exp_count vectors and reports a pass verdict.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, exp_count      run start pulse and expected vector count (sampled in IDLE/DONE)
//   in_valid, in_ready    vector handshake; in_ready is high only in RUN
//   a, b, cin, sum, carry stimulus and the adder's response
//   sum_match/mismatch    sum compare counters (saturating)
//   carry_match/mismatch  carry compare counters (saturating)
//   seen_count            vectors accepted this run
//   busy, done, pass      run status and verdict
module fa_result_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             sum,
    input  logic             carry,
    output logic [CNT_W-1:0] sum_match,
    output logic [CNT_W-1:0] sum_mismatch,
    output logic [CNT_W-1:0] carry_match,
    output logic [CNT_W-1:0] carry_mismatch,
    output logic [CNT_W-1:0] seen_count,
    output logic             busy,
    output logic             done,
    output logic             pass
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] exp_q, exp_d, seen_q, seen_d, seen_inc;
    logic [CNT_W-1:0] sm_q, sm_d, smm_q, smm_d, cm_q, cm_d, cmm_q, cmm_d;
    logic             vld_q, vld_d;
    logic [4:0]       vec_q, vec_d;
    logic             accept, restart, exp_sum, exp_carry;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready = state_q == RUN;
    assign busy     = state_q == RUN || state_q == DRAIN;
    assign done     = state_q == DONE;
    assign pass     = done && sm_q == exp_q && smm_q == '0 && cm_q == exp_q && cmm_q == '0;

    assign sum_match      = sm_q;
    assign sum_mismatch   = smm_q;
    assign carry_match    = cm_q;
    assign carry_mismatch = cmm_q;
    assign seen_count     = seen_q;

    always_comb begin
        accept    = in_valid && in_ready;
        restart   = start && (state_q == IDLE || state_q == DONE);
        // compare stage layout: {a, b, cin, sum, carry}
        exp_sum   = vec_q[4] ^ vec_q[3] ^ vec_q[2];
        exp_carry = (vec_q[4] & vec_q[3]) | (vec_q[4] & vec_q[2]) | (vec_q[3] & vec_q[2]);
        seen_inc  = sat_inc(seen_q);
        state_d   = state_q;
        exp_d     = exp_q;
        seen_d    = accept ? seen_inc : seen_q;
        vld_d     = accept;
        vec_d     = accept ? {a, b, cin, sum, carry} : vec_q;
        sm_d      = (vld_q && vec_q[1] == exp_sum)   ? sat_inc(sm_q)  : sm_q;
        smm_d     = (vld_q && vec_q[1] != exp_sum)   ? sat_inc(smm_q) : smm_q;
        cm_d      = (vld_q && vec_q[0] == exp_carry) ? sat_inc(cm_q)  : cm_q;
        cmm_d     = (vld_q && vec_q[0] != exp_carry) ? sat_inc(cmm_q) : cmm_q;
        case (state_q)
            RUN:     state_d = (accept && seen_inc == exp_q) ? DRAIN : RUN;
            // the last accepted vector retires from the compare stage on this edge
            DRAIN:   state_d = DONE;
            default: state_d = restart ? ((exp_count == '0) ? DONE : RUN) : state_q;
        endcase
        if (restart) begin
            exp_d  = exp_count;
            seen_d = '0;
            vld_d  = 1'b0;
            sm_d   = '0;
            smm_d  = '0;
            cm_d   = '0;
            cmm_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            seen_q  <= '0;
            vld_q   <= 1'b0;
            vec_q   <= '0;
            sm_q    <= '0;
            smm_q   <= '0;
            cm_q    <= '0;
            cmm_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            seen_q  <= seen_d;
            vld_q   <= vld_d;
            vec_q   <= vec_d;
            sm_q    <= sm_d;
            smm_q   <= smm_d;
            cm_q    <= cm_d;
            cmm_q   <= cmm_d;
        end
    end
endmodule
